// File: rtl/frame_writer_if.sv
// Upstream word stream into frame_writer: valid/ready handshake carrying one
// frame word plus a start-of-frame marker. The source drives the master
// modport, frame_writer uses the slave modport.
interface frame_writer_if #(
  parameter int WORD_W = 32
);
  logic              in_valid;
  logic              in_ready;
  logic [WORD_W-1:0] in_data;
  logic              in_sof;

  modport master (
    output in_valid,
    output in_data,
    output in_sof,
    input  in_ready
  );

  modport slave (
    input  in_valid,
    input  in_data,
    input  in_sof,
    output in_ready
  );
endinterface

// File: rtl/frame_writer.sv
// frame_writer: producer side of the 16-word frame register file.
// Collects a stream of words into a 4x4 frame (word k -> slot k), then
// commits it with a two-cycle write strobe: the small group (Small_or_Big=0)
// first, then the big group (Small_or_Big=1) together with frame_done.
// Optional build macro FRAME_WRITER_BYTE_SWAP_EN: byte-reverse every captured
// word before storage (WORD_W must then be 32). Handshake and timing are the
// same in both builds.
module frame_writer #(
  parameter int WORD_W    = 32,
  parameter int NUM_WORDS = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  frame_writer_if.slave     bus,
  output logic [WORD_W-1:0] frame_0_out,
  output logic [WORD_W-1:0] frame_1_out,
  output logic [WORD_W-1:0] frame_2_out,
  output logic [WORD_W-1:0] frame_3_out,
  output logic [WORD_W-1:0] frame_4_out,
  output logic [WORD_W-1:0] frame_5_out,
  output logic [WORD_W-1:0] frame_6_out,
  output logic [WORD_W-1:0] frame_7_out,
  output logic [WORD_W-1:0] frame_8_out,
  output logic [WORD_W-1:0] frame_9_out,
  output logic [WORD_W-1:0] frame_10_out,
  output logic [WORD_W-1:0] frame_11_out,
  output logic [WORD_W-1:0] frame_12_out,
  output logic [WORD_W-1:0] frame_13_out,
  output logic [WORD_W-1:0] frame_14_out,
  output logic [WORD_W-1:0] frame_15_out,
  output logic              write,
  output logic              Small_or_Big,
  output logic              frame_done,
  output logic              busy
);

  typedef enum logic [1:0] {
    ST_COLLECT  = 2'd0,
    ST_WR_SMALL = 2'd1,
    ST_WR_BIG   = 2'd2
  } state_t;

  state_t            state_r;
  logic [3:0]        idx_r;
  logic [WORD_W-1:0] frame_r [NUM_WORDS];
  logic              write_r;
  logic              small_or_big_r;
  logic              frame_done_r;

  // Word transformation applied on capture (identity unless byte swap is built in).
  function automatic logic [WORD_W-1:0] store_word(input logic [WORD_W-1:0] w);
`ifdef FRAME_WRITER_BYTE_SWAP_EN
    store_word = {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    store_word = w;
`endif
  endfunction

  // Collect/commit FSM; strobe outputs are registered so they are set on the
  // same edge that enters the state they belong to.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r        <= ST_COLLECT;
      idx_r          <= 4'd0;
      write_r        <= 1'b0;
      small_or_big_r <= 1'b0;
      frame_done_r   <= 1'b0;
      for (int i = 0; i < NUM_WORDS; i++) begin
        frame_r[i] <= '0;
      end
    end else begin
      case (state_r)
        ST_COLLECT: begin
          write_r        <= 1'b0;
          small_or_big_r <= 1'b0;
          frame_done_r   <= 1'b0;
          // in_ready is high throughout COLLECT once out of reset, so a
          // valid word here is always a transfer.
          if (bus.in_valid) begin
            if (bus.in_sof) begin
              // Restart: slot 0 is rewritten, older slots are left as-is.
              frame_r[0] <= store_word(bus.in_data);
              idx_r      <= 4'd1;
            end else begin
              frame_r[idx_r] <= store_word(bus.in_data);
              if (idx_r == 4'd15) begin
                idx_r   <= 4'd0;
                state_r <= ST_WR_SMALL;
                write_r <= 1'b1;
              end else begin
                idx_r <= idx_r + 4'd1;
              end
            end
          end
        end
        ST_WR_SMALL: begin
          write_r        <= 1'b1;
          small_or_big_r <= 1'b1;
          frame_done_r   <= 1'b1;
          state_r        <= ST_WR_BIG;
        end
        ST_WR_BIG: begin
          write_r        <= 1'b0;
          small_or_big_r <= 1'b0;
          frame_done_r   <= 1'b0;
          state_r        <= ST_COLLECT;
        end
        default: begin
          write_r        <= 1'b0;
          small_or_big_r <= 1'b0;
          frame_done_r   <= 1'b0;
          idx_r          <= 4'd0;
          state_r        <= ST_COLLECT;
        end
      endcase
    end
  end

  assign bus.in_ready = (state_r == ST_COLLECT) && rst_n;
  assign busy         = (state_r != ST_COLLECT);
  assign write        = write_r;
  assign Small_or_Big = small_or_big_r;
  assign frame_done   = frame_done_r;

  assign frame_0_out  = frame_r[0];
  assign frame_1_out  = frame_r[1];
  assign frame_2_out  = frame_r[2];
  assign frame_3_out  = frame_r[3];
  assign frame_4_out  = frame_r[4];
  assign frame_5_out  = frame_r[5];
  assign frame_6_out  = frame_r[6];
  assign frame_7_out  = frame_r[7];
  assign frame_8_out  = frame_r[8];
  assign frame_9_out  = frame_r[9];
  assign frame_10_out = frame_r[10];
  assign frame_11_out = frame_r[11];
  assign frame_12_out = frame_r[12];
  assign frame_13_out = frame_r[13];
  assign frame_14_out = frame_r[14];
  assign frame_15_out = frame_r[15];

endmodule

// File: tb/tb_frame_writer.sv
// Directed bench for frame_writer: frame assembly, commit strobes, sof
// restart, reset during commit, back-to-back throughput and word storage.
module tb_frame_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] frame_out [16];
  logic        write;
  logic        Small_or_Big;
  logic        frame_done;
  logic        busy;

  int vectors     = 0;
  int miscompares = 0;
  int write_cnt   = 0;
  int done_cnt    = 0;
  int cyc         = 0;
  int w0, d0, e1, e2;

  frame_writer_if #(.WORD_W(32)) bus ();

  frame_writer #(.WORD_W(32), .NUM_WORDS(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .frame_0_out  (frame_out[0]),
    .frame_1_out  (frame_out[1]),
    .frame_2_out  (frame_out[2]),
    .frame_3_out  (frame_out[3]),
    .frame_4_out  (frame_out[4]),
    .frame_5_out  (frame_out[5]),
    .frame_6_out  (frame_out[6]),
    .frame_7_out  (frame_out[7]),
    .frame_8_out  (frame_out[8]),
    .frame_9_out  (frame_out[9]),
    .frame_10_out (frame_out[10]),
    .frame_11_out (frame_out[11]),
    .frame_12_out (frame_out[12]),
    .frame_13_out (frame_out[13]),
    .frame_14_out (frame_out[14]),
    .frame_15_out (frame_out[15]),
    .write        (write),
    .Small_or_Big (Small_or_Big),
    .frame_done   (frame_done),
    .busy         (busy)
  );

  // 10 ns clock.
  always #5 clk = ~clk;

  // Rising-edge cycle counter for latency measurements.
  always @(posedge clk) cyc <= cyc + 1;

  // Count strobe cycles, sampled mid-cycle.
  always @(negedge clk) begin
    if (write === 1'b1) write_cnt <= write_cnt + 1;
    if (frame_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  function automatic logic [31:0] exp_word(input logic [31:0] w);
`ifdef FRAME_WRITER_BYTE_SWAP_EN
    exp_word = {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
    exp_word = w;
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    vectors++;
    assert (obs === exp_v) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [31:0] data, input logic sof);
    bus.in_valid = 1'b1;
    bus.in_data  = data;
    bus.in_sof   = sof;
    tick();
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
    bus.in_data  = 32'hFFFF_FFFF;
    bus.in_sof   = 1'b0;
  endtask

  initial begin
    idle();
    rst_n = 1'b0;
    tick();
    tick();

    // ---- Test 1: reset state, then a plain 16-word frame
    check("rst_write", {31'd0, write}, 32'd0);
    check("rst_sob", {31'd0, Small_or_Big}, 32'd0);
    check("rst_done", {31'd0, frame_done}, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ready_in_reset", {31'd0, bus.in_ready}, 32'd0);
    check("rst_frame0", frame_out[0], 32'd0);
    check("rst_frame15", frame_out[15], 32'd0);
    rst_n = 1'b1;
    #1;
    check("rst_ready_after", {31'd0, bus.in_ready}, 32'd1);

    w0 = write_cnt;
    d0 = done_cnt;
    for (int k = 0; k < 16; k++) send(32'hA000_0000 + 32'(k), (k == 0));
    idle();
    check("t1_small_write", {31'd0, write}, 32'd1);
    check("t1_small_sob", {31'd0, Small_or_Big}, 32'd0);
    check("t1_small_done", {31'd0, frame_done}, 32'd0);
    check("t1_small_ready", {31'd0, bus.in_ready}, 32'd0);
    check("t1_small_busy", {31'd0, busy}, 32'd1);
    tick();
    check("t1_big_write", {31'd0, write}, 32'd1);
    check("t1_big_sob", {31'd0, Small_or_Big}, 32'd1);
    check("t1_big_done", {31'd0, frame_done}, 32'd1);
    check("t1_big_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    check("t1_after_write", {31'd0, write}, 32'd0);
    check("t1_after_sob", {31'd0, Small_or_Big}, 32'd0);
    check("t1_after_done", {31'd0, frame_done}, 32'd0);
    check("t1_after_ready", {31'd0, bus.in_ready}, 32'd1);
    check("t1_after_busy", {31'd0, busy}, 32'd0);
    for (int k = 0; k < 16; k++)
      check($sformatf("t1_frame%0d", k), frame_out[k], exp_word(32'hA000_0000 + 32'(k)));
    check("t1_write_cycles", 32'(write_cnt - w0), 32'd2);
    check("t1_done_cycles", 32'(done_cnt - d0), 32'd1);

    // ---- Test 2: in_valid toggled every other cycle
    w0 = write_cnt;
    d0 = done_cnt;
    for (int k = 0; k < 16; k++) begin
      send(32'hC000_0000 + 32'(k), (k == 0));
      if (k != 15) begin
        idle();
        tick();
        check($sformatf("t2_no_write_%0d", k), {31'd0, write}, 32'd0);
      end
    end
    idle();
    check("t2_small_write", {31'd0, write}, 32'd1);
    check("t2_small_sob", {31'd0, Small_or_Big}, 32'd0);
    tick();
    check("t2_big_sob", {31'd0, Small_or_Big}, 32'd1);
    check("t2_big_done", {31'd0, frame_done}, 32'd1);
    tick();
    tick();
    for (int k = 0; k < 16; k++)
      check($sformatf("t2_frame%0d", k), frame_out[k], exp_word(32'hC000_0000 + 32'(k)));
    check("t2_write_cycles", 32'(write_cnt - w0), 32'd2);
    check("t2_done_cycles", 32'(done_cnt - d0), 32'd1);

    // ---- Test 3: partial frame discarded by a new sof
    w0 = write_cnt;
    d0 = done_cnt;
    for (int k = 0; k < 5; k++) send(32'h0000_0200 + 32'(k), (k == 0));
    send(32'hDEAD_BEEF, 1'b1);
    for (int k = 0; k < 15; k++) send(32'h0000_0100 + 32'(k), 1'b0);
    idle();
    tick();
    tick();
    tick();
    check("t3_frame0", frame_out[0], exp_word(32'hDEAD_BEEF));
    for (int k = 1; k < 16; k++)
      check($sformatf("t3_frame%0d", k), frame_out[k], exp_word(32'h0000_0100 + 32'(k - 1)));
    check("t3_write_cycles", 32'(write_cnt - w0), 32'd2);
    check("t3_done_cycles", 32'(done_cnt - d0), 32'd1);

    // ---- Test 4: reset asserted during the WR_SMALL cycle
    w0 = write_cnt;
    d0 = done_cnt;
    for (int k = 0; k < 16; k++) send(32'h0000_0300 + 32'(k), (k == 0));
    idle();
    check("t4_in_small", {31'd0, write}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("t4_ready_in_reset", {31'd0, bus.in_ready}, 32'd0);
    tick();
    check("t4_write", {31'd0, write}, 32'd0);
    check("t4_sob", {31'd0, Small_or_Big}, 32'd0);
    check("t4_done", {31'd0, frame_done}, 32'd0);
    check("t4_busy", {31'd0, busy}, 32'd0);
    for (int k = 0; k < 16; k++)
      check($sformatf("t4_frame%0d", k), frame_out[k], 32'd0);
    rst_n = 1'b1;
    tick();
    check("t4_ready", {31'd0, bus.in_ready}, 32'd1);
    check("t4_write_late", {31'd0, write}, 32'd0);
    check("t4_write_cycles", 32'(write_cnt - w0), 32'd1);
    check("t4_done_cycles", 32'(done_cnt - d0), 32'd0);

    // ---- Test 5: two frames back-to-back, in_valid held high
    w0 = write_cnt;
    d0 = done_cnt;
    for (int k = 0; k < 16; k++) send(32'h0000_0400 + 32'(k), (k == 0));
    e1 = cyc;
    bus.in_valid = 1'b1;
    bus.in_data  = 32'h0BAD_0BAD;
    bus.in_sof   = 1'b1;
    check("t5_small_ready", {31'd0, bus.in_ready}, 32'd0);
    tick();
    check("t5_big_ready", {31'd0, bus.in_ready}, 32'd0);
    check("t5_big_done", {31'd0, frame_done}, 32'd1);
    tick();
    check("t5_ready_after_big", {31'd0, bus.in_ready}, 32'd1);
    check("t5_junk_ignored", frame_out[0], exp_word(32'h0000_0400));
    for (int k = 0; k < 16; k++) send(32'h0000_0500 + 32'(k), (k == 0));
    e2 = cyc;
    idle();
    check("t5_second_write", {31'd0, write}, 32'd1);
    tick();
    tick();
    check("t5_pair_spacing", 32'(e2 - e1), 32'd18);
    for (int k = 0; k < 16; k++)
      check($sformatf("t5_frame%0d", k), frame_out[k], exp_word(32'h0000_0500 + 32'(k)));
    check("t5_write_cycles", 32'(write_cnt - w0), 32'd4);
    check("t5_done_cycles", 32'(done_cnt - d0), 32'd2);

    // ---- Test 6: storage order of bytes in a captured word
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    send(32'h1122_3344, 1'b1);
    idle();
`ifdef FRAME_WRITER_BYTE_SWAP_EN
    check("t6_slot0", frame_out[0], 32'h4433_2211);
`else
    check("t6_slot0", frame_out[0], 32'h1122_3344);
`endif
    check("t6_slot1", frame_out[1], 32'd0);
    check("t6_ready", {31'd0, bus.in_ready}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
